// File: rtl/cgra_boot_pkg.sv
// Shared types for the CGRA boot sequencer: state encoding, output bundle and
// the per-state output decode.
package cgra_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG_RST  = 3'd1,
        ST_CFG_RUN  = 3'd2,
        ST_CFG_GAP  = 3'd3,
        ST_CGRA_RST = 3'd4,
        ST_RUN      = 3'd5,
        ST_ERROR    = 3'd6,
        ST_UNUSED   = 3'd7
    } boot_state_e;

    typedef struct packed {
        logic cfg_clk_en;
        logic cfg_rst;
        logic cfgr_rst;
        logic cfgr_en;
        logic cgra_clk_en;
        logic cgra_rst;
        logic riscv_en;
        logic busy;
        logic error;
    } boot_out_t;

    function automatic boot_out_t boot_outputs(input boot_state_e s);
        boot_out_t o;
        case (s)
            ST_CFG_RST:  o = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            ST_CFG_RUN:  o = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            ST_CFG_GAP:  o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            ST_CGRA_RST: o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            ST_RUN:      o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            ST_ERROR:    o = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            default:     o = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cgra_boot_sequencer.sv
// Boot sequencer for the hybrid RISC-V/CGRA system: config reset, configurator
// run with timeout, config clock gate-off, CGRA reset release, core release.
module cgra_boot_sequencer
    import cgra_boot_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 1,
    parameter int unsigned DONE_TIMEOUT = 65535,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       restart_i,
    input  logic       configurator_done_i,
    output logic       config_clock_en_o,
    output logic       config_reset_o,
    output logic       configurator_reset_o,
    output logic       configurator_enable_o,
    output logic       cgra_clock_en_o,
    output logic       cgra_reset_o,
    output logic       riscv_enable_o,
    output logic       busy_o,
    output logic       error_o,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(DONE_TIMEOUT - 1);

    boot_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    boot_out_t        out_q, out_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CFG_RST;
                    cnt_d   = RST_LOAD;
                end
            end
            ST_CFG_RST: begin
                if (cnt_q == '0) begin
                    state_d = ST_CFG_RUN;
                    cnt_d   = TO_LOAD;
                end
            end
            ST_CFG_RUN: begin
                // done is checked first so it wins over a simultaneous expiry
                if (configurator_done_i) begin
                    state_d = ST_CFG_GAP;
                    cnt_d   = GAP_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_ERROR;
                end
            end
            ST_CFG_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_CGRA_RST;
                    cnt_d   = RST_LOAD;
                end
            end
            ST_CGRA_RST: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (restart_i && (state_q != ST_IDLE) && (state_q != ST_UNUSED)) begin
            state_d = ST_CFG_RST;
            cnt_d   = RST_LOAD;
        end

        // decode from the next state so the output flops track state_q exactly
        out_d = boot_outputs(state_d);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= boot_outputs(ST_IDLE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign config_clock_en_o     = out_q.cfg_clk_en;
    assign config_reset_o        = out_q.cfg_rst;
    assign configurator_reset_o  = out_q.cfgr_rst;
    assign configurator_enable_o = out_q.cfgr_en;
    assign cgra_clock_en_o       = out_q.cgra_clk_en;
    assign cgra_reset_o          = out_q.cgra_rst;
    assign riscv_enable_o        = out_q.riscv_en;
    assign busy_o                = out_q.busy;
    assign error_o               = out_q.error;
    assign state_o               = state_q;

endmodule

// File: tb/tb_cgra_boot_sequencer.sv
// Directed bench for cgra_boot_sequencer with RESET_CYCLES=4, GAP_CYCLES=1,
// DONE_TIMEOUT=16; expected patterns come from the per-state output table.
module tb_cgra_boot_sequencer;

    localparam int unsigned RC = 4;
    localparam int unsigned GC = 1;
    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       restart_i = 1'b0;
    logic       done_i = 1'b0;
    logic       cfg_clk_en, cfg_rst, cfgr_rst, cfgr_en, cgra_clk_en, cgra_rst;
    logic       riscv_en, busy, error;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cgra_boot_sequencer #(
        .RESET_CYCLES(RC),
        .GAP_CYCLES  (GC),
        .DONE_TIMEOUT(TO),
        .CNT_W       (16)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .start_i              (start_i),
        .restart_i            (restart_i),
        .configurator_done_i  (done_i),
        .config_clock_en_o    (cfg_clk_en),
        .config_reset_o       (cfg_rst),
        .configurator_reset_o (cfgr_rst),
        .configurator_enable_o(cfgr_en),
        .cgra_clock_en_o      (cgra_clk_en),
        .cgra_reset_o         (cgra_rst),
        .riscv_enable_o       (riscv_en),
        .busy_o               (busy),
        .error_o              (error),
        .state_o              (state)
    );

    // cfg_clk_en/cfg_rst/cfgr_rst/cfgr_en/cgra_clk_en/cgra_rst/riscv_en/busy/error
    function automatic logic [8:0] pat(input int s);
        case (s)
            0:       return 9'b111001000;
            1:       return 9'b111001010;
            2:       return 9'b100101010;
            3:       return 9'b000001010;
            4:       return 9'b000011010;
            5:       return 9'b000010100;
            6:       return 9'b011001001;
            default: return 9'b000000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int s);
        check({tag, ".state"}, 32'(state), 32'(s));
        check({tag, ".outs"},
              32'({cfg_clk_en, cfg_rst, cfgr_rst, cfgr_en, cgra_clk_en, cgra_rst,
                   riscv_en, busy, error}),
              32'(pat(s)));
    endtask

    // n edges: state must still be s_prev after n-1 and become s_new on the nth
    task automatic step_check(input string tag, input int n, input int s_prev, input int s_new);
        if (n > 1) begin
            repeat (n - 1) tick();
            check({tag, ".hold"}, 32'(state), 32'(s_prev));
        end
        tick();
        check_state(tag, s_new);
    endtask

    task automatic pulse_restart();
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
    endtask

    // from CFG_RST: done arrives done_delay edges after CFG_RUN entry, then on to RUN
    task automatic run_seq(input string tag, input int done_delay);
        step_check({tag, ".cfgrun"}, RC, 1, 2);
        repeat (done_delay - 1) tick();
        check({tag, ".wait"}, 32'(state), 32'd2);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check_state({tag, ".gap"}, 3);
        step_check({tag, ".cgrarst"}, GC, 3, 4);
        step_check({tag, ".run"}, RC, 4, 5);
    endtask

    initial begin
        repeat (4) tick();
        check_state("reset", 0);
        rst_ni = 1'b1;
        tick();
        check_state("idle", 0);

        // nominal boot
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_state("start", 1);
        run_seq("boot", 5);

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_state("start_in_run", 5);

        // restart from RUN, then from CGRA_RST, repeating the same latencies
        pulse_restart();
        check_state("restart_run", 1);
        step_check("rs1.cfgrun", RC, 1, 2);
        repeat (4) tick();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check_state("rs1.gap", 3);
        step_check("rs1.cgrarst", GC, 3, 4);
        tick();
        pulse_restart();
        check_state("restart_cgrarst", 1);
        run_seq("rs2", 5);

        // timeout to ERROR, held until restart
        pulse_restart();
        check_state("to.start", 1);
        step_check("to.cfgrun", RC, 1, 2);
        step_check("to.err", TO, 2, 6);
        repeat (3) tick();
        check_state("to.held", 6);
        pulse_restart();
        check_state("restart_err", 1);

        // done held high through CFG_RST is ignored until the first CFG_RUN edge
        done_i = 1'b1;
        step_check("dh.cfgrun", RC, 1, 2);
        tick();
        done_i = 1'b0;
        check_state("dh.gap", 3);
        step_check("dh.cgrarst", GC, 3, 4);
        step_check("dh.run", RC, 4, 5);

        // done on the expiry edge wins
        pulse_restart();
        check_state("race.start", 1);
        run_seq("race", TO);
        check("race.noerr", 32'(error), 32'd0);

        // synchronous reset mid CFG_RUN
        pulse_restart();
        step_check("mr.cfgrun", RC, 1, 2);
        repeat (2) tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check_state("midreset", 0);

        pulse_restart();
        check_state("restart_idle", 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_state("restart_after_reset", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
